// File: rtl/mux_uart_pkg.sv
// mux_uart_pkg
// Shared definitions for the MUX channel 0 serial port controller:
//   - register offsets relative to the BASE address
//   - bit positions inside the status register
//   - state encodings for the transmit and receive state machines
package mux_uart_pkg;

  // Register offsets from BASE
  localparam int STATUS_OFS = 0;
  localparam int DATA_OFS   = 1;

  // Status register bit positions
  localparam int ST_RXAV  = 0;
  localparam int ST_TXRDY = 1;
  localparam int ST_OVR   = 2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } txState_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rxState_e;

endpackage

// File: rtl/mux_uart_if.sv
// mux_uart_if
// CPU6 bus view of the serial port registers.
//   address   CPU6 bus address (driven by the CPU)
//   write_en  write strobe, sampled on the rising clock edge
//   data_in   write data
//   data_out  register read data (0 when the port is not selected)
//   sel       high when address hits the status or data register
// Modports: master = CPU side, slave = the serial port.
interface mux_uart_if;

  logic [15:0] address;
  logic        write_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        sel;

  modport master (
    output address,
    output write_en,
    output data_in,
    input  data_out,
    input  sel
  );

  modport slave (
    input  address,
    input  write_en,
    input  data_in,
    output data_out,
    output sel
  );

endinterface

// File: rtl/mux_uart_rx.sv
// mux_uart_rx
// 8N1 serial receiver used when MUX_RX_EN is defined.
//   clock      system clock
//   reset      asynchronous active-high reset
//   rxd        asynchronous serial input (idle high)
//   rx_byte    last correctly framed byte
//   rx_strobe  one-cycle pulse when rx_byte has just been updated
// A falling edge on the synchronised line starts a frame. The start bit is
// rechecked half a bit later so that all following samples land mid-bit;
// a frame whose stop bit reads 0 is dropped without a strobe.
module mux_uart_rx
  import mux_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_strobe
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic           rxMeta_q;
  logic           rxSync_q;
  logic           rxPrev_q;
  rxState_e       state_q;
  logic [CW-1:0]  baudCnt_q;
  logic [2:0]     bitCnt_q;
  logic [7:0]     shift_q;
  logic [7:0]     byte_q;
  logic           strobe_q;

  // Two-flop synchroniser plus one extra stage for falling-edge detection.
  // Reset to the idle-high line level so reset release is not seen as a start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= rxd;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  // Receive FSM with bit-timing counter; strobe and byte are registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      baudCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          baudCnt_q <= '0;
          if (rxPrev_q && !rxSync_q) begin
            state_q <= RX_START;
          end
        end
        RX_START: begin
          if (baudCnt_q == HALF_LAST) begin
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            // A line back high at mid start bit was a glitch, not a frame
            state_q   <= rxSync_q ? RX_IDLE : RX_DATA;
          end else begin
            baudCnt_q <= baudCnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (baudCnt_q == BAUD_LAST) begin
            baudCnt_q <= '0;
            shift_q   <= {rxSync_q, shift_q[7:1]};
            bitCnt_q  <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              state_q <= RX_STOP;
            end
          end else begin
            baudCnt_q <= baudCnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (baudCnt_q == BAUD_LAST) begin
            baudCnt_q <= '0;
            state_q   <= RX_IDLE;
            if (rxSync_q) begin
              byte_q   <= shift_q;
              strobe_q <= 1'b1;
            end
          end else begin
            baudCnt_q <= baudCnt_q + CW'(1);
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_byte   = byte_q;
  assign rx_strobe = strobe_q;

endmodule

// File: rtl/mux_uart.sv
// mux_uart
// Memory-mapped serial port for MUX channel 0 on the CPU6 bus.
//   clock  system clock
//   reset  asynchronous active-high reset
//   bus    CPU6 register bus (mux_uart_if.slave): BASE = status, BASE+1 = data
//   txd    serial transmit, 8N1, idle high
//   rxd    serial receive (only used when MUX_RX_EN is defined)
// Status bits: 0 RX_AVAIL, 1 TX_READY, 2 RX_OVERRUN.
// Optional feature macro: MUX_RX_EN enables the receiver (mux_uart_rx).
module mux_uart
  import mux_uart_pkg::*;
#(
  parameter logic [15:0] BASE         = 16'hF200,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic      clock,
  input  logic      reset,
  mux_uart_if.slave bus,
  output logic      txd,
  input  logic      rxd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [15:0]   STATUS_ADDR = BASE + 16'(STATUS_OFS);
  localparam logic [15:0]   DATA_ADDR   = BASE + 16'(DATA_OFS);

  logic hitStatus;
  logic hitData;
  logic wrData;

  assign hitStatus = (bus.address == STATUS_ADDR);
  assign hitData   = (bus.address == DATA_ADDR);
  assign bus.sel   = hitStatus | hitData;
  assign wrData    = hitData & bus.write_en;

  // ---------------------------------------------------------------- transmit
  txState_e       txState_q;
  logic [CW-1:0]  baudCnt_q;
  logic [2:0]     bitCnt_q;
  logic [7:0]     shift_q;
  logic           txd_q;
  logic [7:0]     hold_q;
  logic           txReady_q;
  logic           baudDone;
  logic           txLoad_d;

  assign baudDone = (baudCnt_q == BAUD_LAST);

  // The holding register moves into the shifter either from idle or right at
  // the end of a stop bit, which is what makes back-to-back frames gapless.
  assign txLoad_d = !txReady_q &&
                    ((txState_q == TX_IDLE) || (txState_q == TX_STOP && baudDone));

  // Holding register: filled by a CPU write only while empty; a transfer to
  // the shifter empties it. Both cannot happen in one cycle since a transfer
  // requires it to be full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      txReady_q <= 1'b1;
      hold_q    <= '0;
    end else if (txLoad_d) begin
      txReady_q <= 1'b1;
    end else if (wrData && txReady_q) begin
      hold_q    <= bus.data_in;
      txReady_q <= 1'b0;
    end
  end

  // Transmit FSM; txd is registered so the line never glitches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      txState_q <= TX_IDLE;
      baudCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      case (txState_q)
        TX_IDLE: begin
          baudCnt_q <= '0;
          if (txLoad_d) begin
            txState_q <= TX_START;
            shift_q   <= hold_q;
            txd_q     <= 1'b0;
          end
        end
        TX_START: begin
          if (baudDone) begin
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            txState_q <= TX_DATA;
            txd_q     <= shift_q[0];
          end else begin
            baudCnt_q <= baudCnt_q + CW'(1);
          end
        end
        TX_DATA: begin
          if (baudDone) begin
            baudCnt_q <= '0;
            bitCnt_q  <= bitCnt_q + 3'd1;
            shift_q   <= {1'b0, shift_q[7:1]};
            if (bitCnt_q == 3'd7) begin
              txState_q <= TX_STOP;
              txd_q     <= 1'b1;
            end else begin
              txd_q <= shift_q[1];
            end
          end else begin
            baudCnt_q <= baudCnt_q + CW'(1);
          end
        end
        TX_STOP: begin
          if (baudDone) begin
            baudCnt_q <= '0;
            if (txLoad_d) begin
              txState_q <= TX_START;
              shift_q   <= hold_q;
              txd_q     <= 1'b0;
            end else begin
              txState_q <= TX_IDLE;
            end
          end else begin
            baudCnt_q <= baudCnt_q + CW'(1);
          end
        end
        default: begin
          txState_q <= TX_IDLE;
          txd_q     <= 1'b1;
        end
      endcase
    end
  end

  assign txd = txd_q;

  // ----------------------------------------------------------------- receive
  logic       rxAvail;
  logic       rxOverrun;
  logic [7:0] rxData;

`ifdef MUX_RX_EN
  logic [7:0] rxByte;
  logic       rxStrobe;
  logic       rdHit;
  logic       rdHitPrev_q;
  logic       rdClear;
  logic       rxAvail_q;
  logic       rxOverrun_q;
  logic [7:0] rxData_q;

  mux_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uRx (
    .clock    (clock),
    .reset    (reset),
    .rxd      (rxd),
    .rx_byte  (rxByte),
    .rx_strobe(rxStrobe)
  );

  // Flags clear only on the rising edge of a data-register read, so a CPU
  // that parks on BASE+1 clears them exactly once.
  assign rdHit   = hitData & ~bus.write_en;
  assign rdClear = rdHit & ~rdHitPrev_q;

  // Receive data register and status flags. A new byte always wins; if it
  // arrives while the previous byte is being read, that read consumed the
  // old byte, so no overrun is flagged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdHitPrev_q <= 1'b0;
      rxAvail_q   <= 1'b0;
      rxOverrun_q <= 1'b0;
      rxData_q    <= '0;
    end else begin
      rdHitPrev_q <= rdHit;
      if (rxStrobe) begin
        rxData_q    <= rxByte;
        rxAvail_q   <= 1'b1;
        rxOverrun_q <= rdClear ? 1'b0 : (rxOverrun_q | rxAvail_q);
      end else if (rdClear) begin
        rxAvail_q   <= 1'b0;
        rxOverrun_q <= 1'b0;
      end
    end
  end

  assign rxAvail   = rxAvail_q;
  assign rxOverrun = rxOverrun_q;
  assign rxData    = rxData_q;
`else
  logic unusedRxd;
  assign unusedRxd = rxd;
  assign rxAvail   = 1'b0;
  assign rxOverrun = 1'b0;
  assign rxData    = 8'h00;
`endif

  // ------------------------------------------------------------ read mux
  logic [7:0] statusByte;

  always_comb begin
    statusByte           = '0;
    statusByte[ST_RXAV]  = rxAvail;
    statusByte[ST_TXRDY] = txReady_q;
    statusByte[ST_OVR]   = rxOverrun;
  end

  assign bus.data_out = hitStatus ? statusByte :
                        hitData   ? rxData     : 8'h00;

endmodule

// File: doc/mux_uart.md
# mux_uart

Memory-mapped serial port controller for MUX channel 0 on the CPU6 bus. It decodes the status and data registers at F200/F201, accepts bytes written by CPU6, and serialises them 8N1 on `txd`. An optional receiver deserialises `rxd` into a readable data register. Its `sel`/`data_out` pair is OR/muxed into the CPU read bus next to `Memory`, replacing the fixed F200 status constant.

## Interface
- `BASE`, 16'hF200, status register address; data register is `BASE+1`.
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; legal range ≥ 4, counter width `$clog2(CLKS_PER_BIT)`.
- `clock`  in  1  system clock, all state on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `address`  in  16  CPU6 bus address.
- `write_en`  in  1  CPU6 write strobe, sampled on posedge `clock`.
- `data_in`  in  8  CPU6 write data.
- `data_out`  out  8  register read data, combinational from `address`; 0 when not selected.
- `sel`  out  1  high when `address` is `BASE` or `BASE+1`.
- `txd`  out  1  serial transmit, idle high.
- `rxd`  in  1  serial receive, asynchronous (used only with `MUX_RX_EN`).

## Operation
- Status (read `BASE`): bit1 TX_READY (holding register empty), bit0 RX_AVAIL, bit2 RX_OVERRUN, others 0. Writes to `BASE` are ignored.
- Data write (`BASE+1`, `write_en`=1): if TX_READY, load holding register and clear TX_READY. If not ready, drop the byte; no state changes.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when the holding register is full. The holding register transfers to the shift register and TX_READY sets in that same cycle.
  - START drives 0 for `CLKS_PER_BIT` cycles.
  - DATA shifts 8 bits LSB first, each `CLKS_PER_BIT` cycles. A 3-bit counter wraps 7 → 0 on exit.
  - STOP drives 1 for `CLKS_PER_BIT` cycles, then returns to IDLE.
  - All 8 bits are sent as written; no masking of bit 7.
- Back-to-back: a write accepted during DATA/STOP waits in the holding register. START follows STOP with no idle gap.
- Data read (`BASE+1`): returns the RX data register. RX_AVAIL and RX_OVERRUN clear on the first posedge where `address==BASE+1` and `write_en`=0 after a non-hit cycle (hit rising edge). A long-held address therefore clears once.
- Reset mid-frame: TX aborts immediately and `txd` goes high. Any partial byte is lost.

## Timing
- Reset values: `txd`=1, TX_READY=1, RX_AVAIL=0, RX_OVERRUN=0, FSM=IDLE. Status reads 8'h02 after reset.
- Write accepted at edge N:
  - status reads 8'h00 after N;
  - `txd` falls after edge N+1;
  - TX_READY returns to 1 after N+1.
- Frame length: exactly 10·`CLKS_PER_BIT` cycles from `txd` fall to STOP end.
- Write and read of status in the same cycle: `data_out` shows pre-edge state.

## Configuration
- `MUX_RX_EN` defined:
  - `rxd` passes through a 2-flop synchroniser;
  - a falling edge starts reception;
  - the start bit is rechecked at `CLKS_PER_BIT/2` and the frame is aborted if high;
  - data bits are sampled mid-bit.
  - Valid stop (1): the byte loads the data register and sets RX_AVAIL. If RX_AVAIL was already set, it also sets RX_OVERRUN and the byte overwrites.
  - Stop = 0 (framing error): the byte is discarded.
- `MUX_RX_EN` undefined:
  - no receiver logic;
  - `rxd` is unused;
  - RX_AVAIL and RX_OVERRUN read 0;
  - data reads return 8'h00.

## Structure
- Package `mux_uart_pkg`:
  - register offsets (`STATUS_OFS`=0, `DATA_OFS`=1);
  - status bit positions (`ST_RXAV`=0, `ST_TXRDY`=1, `ST_OVR`=2);
  - TX state enum;
  - RX state enum (IDLE, START, DATA, STOP).
- Sub-module `mux_uart_rx`: synchroniser, RX FSM, bit-timing counter. It outputs `rx_byte[7:0]` and a one-cycle `rx_strobe`. It is instantiated only under `MUX_RX_EN`.
- Register decode, holding register and TX FSM live in `mux_uart`.

## Test plan
- Reset, then read F200 → 8'h02; `txd`=1; `sel`=1 at F200/F201, 0 at F1FF and F202.
- Write 8'h48 to F201 with `CLKS_PER_BIT`=4 → `txd` low for 4 cycles, then bits 0,0,0,1,0,0,1,0 at 4 cycles each, then high for 4 cycles. Total 40 cycles.
- Two consecutive writes 8'h55, 8'hAA: second is held, F200 reads 8'h00 until transfer, and the frames run contiguously. A third write while not ready is dropped, so only 2 frames appear.
- Assert `reset` mid-DATA → `txd`=1 immediately; F200 reads 8'h02 with no clock edge required.
- `MUX_RX_EN`: drive 8'hC3 on `rxd` → F200 reads 8'h03, F201 reads 8'hC3, and a subsequent F200 read gives 8'h02.
  - A second byte sent before reading sets 8'h07.
  - A frame with stop=0 leaves status unchanged.
- Without `MUX_RX_EN`: toggle `rxd` arbitrarily → F200 stays 8'h02 and F201 reads 8'h00.
